// File: rtl/rescale_job_sequencer.sv
// rescale_job_sequencer
//   Job-level front end for the rescale engine. Requests (x, y) are queued
//   and tagged. Each request is popped and range-checked. Legal jobs are
//   launched on the engine with a one-cycle GO pulse and then watched for
//   DONE/ERROR under a watchdog. The engine is held in reset for two cycles
//   after a timeout or an abort. One status record is emitted for every job
//   that is popped.
// Ports
//   CLOCK, RESETN         : clock, async active-low reset
//   job_valid/job_ready   : request handshake, job_x/job_y = requested size
//   abort                 : cancel running job and flush the queue (level)
//   GO, X_IN, Y_IN        : engine start pulse and held size
//   DONE, ERROR           : engine completion / error
//   eng_rst_n             : engine reset (low for 2 cycles on recovery)
//   stat_valid/code/tag   : one-cycle status strobe
//                           code: 0 done, 1 error, 2 timeout/abort, 3 rejected
//   busy, q_count         : sequencer not idle, queued entries
module rescale_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int MAX_X   = 640,
  parameter int MAX_Y   = 480,
  parameter int TIMEOUT = 1048576
) (
  input  logic                     CLOCK,
  input  logic                     RESETN,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [9:0]               job_x,
  input  logic [9:0]               job_y,
  input  logic                     abort,
  output logic                     GO,
  output logic [9:0]               X_IN,
  output logic [9:0]               Y_IN,
  input  logic                     DONE,
  input  logic                     ERROR,
  output logic                     eng_rst_n,
  output logic                     stat_valid,
  output logic [1:0]               stat_code,
  output logic [1:0]               stat_tag,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [9:0]     MX      = 10'(MAX_X);
  localparam logic [9:0]     MY      = 10'(MAX_Y);

  localparam logic [1:0] C_DONE = 2'd0;
  localparam logic [1:0] C_ERR  = 2'd1;
  localparam logic [1:0] C_TO   = 2'd2;
  localparam logic [1:0] C_REJ  = 2'd3;

  typedef struct packed {
    logic [1:0] tag;
    logic [9:0] x;
    logic [9:0] y;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_RECOVER, S_REPORT
  } state_t;

  state_t          st, nxt;
  job_t            mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   count;
  logic [1:0]      tag_cnt, tag_q;
  logic [1:0]      code_q, code_nxt;
  logic [WDW-1:0]  wdog;
  logic            abt_q, rec_q, eng_rst_q;
  logic            push, pop, flush, code_ld, wd_clr, wd_inc, legal;

  assign job_ready  = (count < CW'(DEPTH)) && !abort;
  assign push       = job_valid && job_ready;
  assign legal      = (X_IN != '0) && (X_IN <= MX) && (Y_IN != '0) && (Y_IN <= MY);

  assign GO         = (st == S_LAUNCH);
  assign stat_valid = (st == S_REPORT);
  assign busy       = (st != S_IDLE);
  assign stat_code  = code_q;
  assign stat_tag   = tag_q;
  assign q_count    = count;
  assign eng_rst_n  = eng_rst_q;

  // next state / control
  always_comb begin
    nxt      = st;
    pop      = 1'b0;
    flush    = 1'b0;
    code_ld  = 1'b0;
    code_nxt = code_q;
    wd_clr   = 1'b0;
    wd_inc   = 1'b0;
    case (st)
      S_IDLE: begin
        // a live abort or one latched while a job was finishing
        if (abort || abt_q) flush = 1'b1;
        else if (count != '0) begin
          pop = 1'b1;
          nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (legal) nxt = S_LAUNCH;
        else begin
          nxt      = S_REPORT;
          code_ld  = 1'b1;
          code_nxt = C_REJ;
        end
      end
      S_LAUNCH: begin
        wd_clr = 1'b1;
        nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          nxt      = S_RECOVER;
          flush    = 1'b1;
          code_ld  = 1'b1;
          code_nxt = C_TO;
        end else if (ERROR) begin
          nxt      = S_REPORT;
          code_ld  = 1'b1;
          code_nxt = C_ERR;
        end else if (DONE) begin
          nxt      = S_REPORT;
          code_ld  = 1'b1;
          code_nxt = C_DONE;
        end else if (wdog == WD_LAST) begin
          nxt      = S_RECOVER;
          code_ld  = 1'b1;
          code_nxt = C_TO;
        end else wd_inc = 1'b1;
      end
      S_RECOVER: if (rec_q) nxt = S_REPORT;
      S_REPORT:  nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) st <= S_IDLE;
    else         st <= nxt;
  end

  // queue storage needs no reset: count gates every read
  always_ff @(posedge CLOCK) begin
    if (push) mem[wp] <= '{tag: tag_cnt, x: job_x, y: job_y};
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wp      <= wp + AW'(1);
        tag_cnt <= tag_cnt + 2'd1;
      end
      if (flush) begin
        // a push in the flush cycle (possible only with a latched abort)
        // survives as the sole entry
        rp    <= wp;
        count <= CW'(push);
      end else begin
        if (pop) rp <= rp + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // job registers, watchdog, recovery, status
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      X_IN      <= '0;
      Y_IN      <= '0;
      tag_q     <= '0;
      code_q    <= '0;
      wdog      <= '0;
      abt_q     <= 1'b0;
      rec_q     <= 1'b0;
      eng_rst_q <= 1'b0;
    end else begin
      if (pop) begin
        X_IN  <= mem[rp].x;
        Y_IN  <= mem[rp].y;
        tag_q <= mem[rp].tag;
      end
      if (code_ld) code_q <= code_nxt;
      if (wd_clr)      wdog <= '0;
      else if (wd_inc) wdog <= wdog + WDW'(1);
      // IDLE always consumes a pending abort via the flush
      if (st == S_IDLE)                abt_q <= 1'b0;
      else if (abort && st != S_WAIT)  abt_q <= 1'b1;
      rec_q     <= (st == S_RECOVER) ? !rec_q : 1'b0;
      // registered on next state so it is low exactly in RECOVER cycles
      eng_rst_q <= (nxt != S_RECOVER);
    end
  end

endmodule
